search_ctrl: RTL and testbench
==============================

Name: search_ctrl

Overview:
- Sequencing controller for the 32x3 search RAM, the 3-bit key comparator and the match-address register.
- Arbitrates single-cycle host writes against search scans on the shared RAM port.
- On start, sweeps RAM addresses 0..DEPTH-1 against a latched key, then reports found/not-found and the first matching address.
- Replaces the loose reset/select/rw control regs with one FSM that owns the RAM address mux and the read/write line.

Parameters:
- DATA_W, 3: RAM word and key width.
- ADDR_W, 5: RAM address width.
- DEPTH, 32: number of RAM words scanned (must be at most 2**ADDR_W).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  search request; level, host holds it until busy=1.
- key  in  DATA_W  search key; sampled only on the start-accept edge.
- wr_en  in  1  host write request.
- wr_addr  in  ADDR_W  host write address.
- wr_data  in  DATA_W  host write data.
- wr_ready  out  1  high when a write is accepted this cycle (state IDLE).
- ram_rw  out  1  RAM control: 1=write, 0=read.
- ram_addr  out  ADDR_W  RAM address: wr_addr in IDLE, scan counter otherwise.
- ram_wdata  out  DATA_W  equals wr_data.
- ram_rdata  in  DATA_W  RAM synchronous read data (1-cycle latency).
- busy  out  1  high in SCAN/LAST.
- done  out  1  one-cycle pulse when a search completes.
- found  out  1  result of the last search.
- match_addr  out  ADDR_W  first matching address; 0 if none.

Behaviour:
- Reset (async assert, sync release): state=IDLE, scan counter=0, key reg=0; outputs busy=0, done=0, found=0, match_addr=0, ram_rw=0. Reset mid-scan aborts the scan with no done pulse.
- IDLE:
  - wr_ready=1.
  - wr_en=1: ram_rw=1 and ram_addr=wr_addr for that cycle; the write completes in one cycle.
  - start=1 with wr_en=0: latch key, clear counter, found, match_addr; go to SCAN.
  - start and wr_en together: the write wins and start stays pending.
- SCAN:
  - ram_rw=0, ram_addr=counter, counter increments each cycle.
  - rd_valid (a 1-cycle-delayed issue flag) gates the compare of ram_rdata against the key reg; the compare refers to address counter-1.
  - Match: found<=1, match_addr<=counter-1, go to DONE. The scan ends early.
  - Issuing address DEPTH-1 goes to LAST.
- LAST: compare the data for DEPTH-1, then go to DONE. found and match_addr are set if it matches.
- DONE: done=1 for exactly one cycle, then IDLE. found and match_addr hold until the next accepted start.
- Latency, counted from the start-accept edge: match at address k gives done k+2 cycles later; no match gives done DEPTH+1 cycles later (33 at default).
- While busy: wr_ready=0, host writes ignored (the host retries), start ignored, key changes ignored.
- Counter width is ADDR_W+1 internally, so DEPTH=2**ADDR_W never wraps falsely.

Optional Feature:
- Macro: SEARCH_COUNT_EN.
- Defined:
  - Adds output match_cnt [ADDR_W:0], reset to 0 and cleared on start.
  - The scan never ends early; it always runs through LAST.
  - Each match increments match_cnt. match_addr holds the first match; found = (match_cnt!=0).
  - done always arrives DEPTH+1 cycles after start.
- Undefined: port absent; first-match early termination as above.

Decomposition:
- Shared package search_pkg holds:
  - state encoding (localparams S_IDLE=2'b00, S_SCAN=2'b01, S_LAST=2'b10, S_DONE=2'b11);
  - RW_WRITE=1'b1 / RW_READ=1'b0;
  - default DATA_W/ADDR_W/DEPTH.
- One natural sub-module: search_addr_gen, the scan counter plus rd_valid delay and last-address detect. The FSM and arbitration stay in search_ctrl.

Test Plan:
- Reset: hold reset=0 mid-SCAN -> next cycle busy=0, done=0, found=0, match_addr=0, ram_rw=0; release -> IDLE, wr_ready=1.
- Write then search: write 3'b101 at 7, 0 elsewhere; start with key=3'b101 -> done exactly 9 cycles after accept, found=1, match_addr=7.
- No match: all words 0, key=3'b111 -> done 33 cycles after accept, found=0, match_addr=0, ram_addr visits 0..31 once each.
- Boundaries: match only at address 0 -> done at +2, match_addr=0; match only at 31 -> done at +33, match_addr=31.
- Arbitration:
  - wr_en and start together in IDLE -> write occurs (ram_rw=1), SCAN entered next cycle.
  - wr_en during busy -> wr_ready=0, ram_rw stays 0, RAM unchanged.
- SEARCH_COUNT_EN: key present at 2, 9, 30 -> done at +33, match_cnt=3, match_addr=2, found=1.

Source files
------------

// File: rtl/search_pkg.sv
// Shared definitions for the search controller slice: FSM state encoding,
// RAM read/write line encoding and the default geometry of the search RAM.
// No logic; imported by search_ctrl and search_addr_gen.
package search_pkg;

    localparam int DATA_W_DEF = 3;
    localparam int ADDR_W_DEF = 5;
    localparam int DEPTH_DEF  = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_SCAN = 2'b01,
        S_LAST = 2'b10,
        S_DONE = 2'b11
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/search_addr_gen.sv
// Scan address generator: counter, read-valid delay and last-address detect.
// Latency: rd_valid follows inc by one cycle, matching the RAM read latency.
// Backpressure: none; the controller advances it with inc every scan cycle.
//
// Ports:
//   clk, reset         clock, asynchronous active-low reset
//   clear              zero the counter (search accepted)
//   inc                a scan read is issued this cycle; advance the counter
//   scan_addr          address being issued this cycle
//   cmp_addr           address whose data is on ram_rdata this cycle
//   rd_valid           ram_rdata holds data from an issued scan read
//   last_issue         the counter points at the final word (DEPTH-1)
module search_addr_gen
    import search_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] scan_addr,
    output logic [ADDR_W-1:0] cmp_addr,
    output logic              rd_valid,
    output logic              last_issue
);

    // One extra bit so that DEPTH == 2**ADDR_W cannot alias back to zero.
    localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W+1)'(DEPTH - 1);

    logic [ADDR_W:0] cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt      <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= inc;
            if (clear) begin
                cnt <= '0;
            end else if (inc) begin
                cnt <= cnt + (ADDR_W+1)'(1);
            end
        end
    end

    assign scan_addr  = cnt[ADDR_W-1:0];
    // Data arriving now was addressed one cycle ago; the counter has moved on.
    assign cmp_addr   = cnt[ADDR_W-1:0] - ADDR_W'(1);
    assign last_issue = (cnt == LAST_CNT);

endmodule

// File: rtl/search_ctrl.sv
// Search controller: arbitrates host writes vs. scans of the search RAM and reports first match.
// Latency: match at address k -> done k+2 cycles after start accept; no match -> DEPTH+1 cycles.
// Backpressure: wr_ready=0 while busy (host retries writes); start/key ignored while busy.
//
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   start, key                  search request (level) and key, key sampled on accept
//   wr_en, wr_addr, wr_data     host single-cycle write; wr_ready high when accepted (IDLE)
//   ram_rw, ram_addr, ram_wdata RAM control (1=write), address mux, write data
//   ram_rdata                   RAM read data, one cycle after the address
//   busy, done                  scan in progress; one-cycle completion pulse
//   found, match_addr           result of the last search (first matching address)
//   match_cnt                   number of matches, only with SEARCH_COUNT_EN defined
//
// Optional feature macro: SEARCH_COUNT_EN. When defined the scan always covers all
// DEPTH words and counts every match; when undefined the scan stops at the first match.
module search_ctrl
    import search_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic              ram_rw,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] match_addr
`ifdef SEARCH_COUNT_EN
    ,
    output logic [ADDR_W:0]   match_cnt
`endif
);

    state_t            state;
    logic [DATA_W-1:0] key_q;

    logic              accept;
    logic              scan_inc;
    logic              hit;
    logic              stop_early;
    logic [ADDR_W-1:0] scan_addr;
    logic [ADDR_W-1:0] cmp_addr;
    logic              rd_valid;
    logic              last_issue;

    // A write in the same cycle as start takes the RAM port; start stays pending.
    assign accept   = (state == S_IDLE) && start && !wr_en;
    assign scan_inc = (state == S_SCAN);

    search_addr_gen #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_addr_gen (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept),
        .inc        (scan_inc),
        .scan_addr  (scan_addr),
        .cmp_addr   (cmp_addr),
        .rd_valid   (rd_valid),
        .last_issue (last_issue)
    );

    // rd_valid masks the first scan cycle, where ram_rdata is stale IDLE data.
    assign hit = rd_valid && (ram_rdata == key_q) &&
                 ((state == S_SCAN) || (state == S_LAST));

`ifdef SEARCH_COUNT_EN
    assign stop_early = 1'b0;
`else
    assign stop_early = hit;
`endif

    // RAM port: the host owns it in IDLE, the scan counter everywhere else.
    assign wr_ready  = (state == S_IDLE);
    assign ram_rw    = ((state == S_IDLE) && wr_en) ? RW_WRITE : RW_READ;
    assign ram_addr  = (state == S_IDLE) ? wr_addr : scan_addr;
    assign ram_wdata = wr_data;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            key_q      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            found      <= 1'b0;
            match_addr <= '0;
`ifdef SEARCH_COUNT_EN
            match_cnt  <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        key_q      <= key;
                        found      <= 1'b0;
                        match_addr <= '0;
`ifdef SEARCH_COUNT_EN
                        match_cnt  <= '0;
`endif
                        busy       <= 1'b1;
                        state      <= S_SCAN;
                    end
                end

                S_SCAN, S_LAST: begin
                    if (hit) begin
                        // Only the first match sets the address; later ones only count.
                        if (!found) begin
                            found      <= 1'b1;
                            match_addr <= cmp_addr;
                        end
`ifdef SEARCH_COUNT_EN
                        match_cnt <= match_cnt + (ADDR_W+1)'(1);
`endif
                    end
                    if ((state == S_LAST) || stop_early) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (last_issue) begin
                        // Final address issued this cycle; its data is compared in LAST.
                        state <= S_LAST;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_search_ctrl.sv
// Directed bench for search_ctrl with a behavioural 32x3 synchronous RAM.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
// Expected latencies: k+2 for first match at k, 33 for full scan (or always 33 with counting).
module tb_search_ctrl;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [2:0] key;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [2:0] wr_data;
    logic       wr_ready;
    logic       ram_rw;
    logic [4:0] ram_addr;
    logic [2:0] ram_wdata;
    logic [2:0] ram_rdata;
    logic       busy;
    logic       done;
    logic       found;
    logic [4:0] match_addr;
`ifdef SEARCH_COUNT_EN
    logic [5:0] match_cnt;
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    logic [2:0] mem [0:31];
    int         addr_log [0:63];
    int         n_log;
    int         last_lat;

    search_ctrl u_dut (
        .clk        (clk),
        .reset      (rst_n),
        .start      (start),
        .key        (key),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ready   (wr_ready),
        .ram_rw     (ram_rw),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .busy       (busy),
        .done       (done),
        .found      (found),
        .match_addr (match_addr)
`ifdef SEARCH_COUNT_EN
        ,
        .match_cnt  (match_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Search RAM model: write-first is irrelevant here, read data is registered.
    always @(posedge clk) begin
        if (ram_rw) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, act, exp);
        end
    endtask

    function automatic int exp_lat(input int k);
        return CNT_EN ? 33 : k + 2;
    endfunction

    task automatic host_write(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 5'(a);
        wr_data = 3'(d);
        @(posedge clk); #1;
        wr_en   = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 32; i++) host_write(i, 0);
    endtask

    // Start a search, log ram_addr on every busy cycle, measure cycles to done.
    task automatic run_search(input logic [2:0] k, input int e_lat, input int e_found,
                              input int e_addr, input string tag);
        int lat;
        start = 1'b1;
        key   = k;
        @(posedge clk); #1;
        start = 1'b0;
        key   = ~k;              // must be ignored after accept
        check({tag, "_busy"}, busy, 1);
        lat   = 0;
        n_log = 0;
        while (!done && lat < 200) begin
            if (busy && n_log < 64) begin
                addr_log[n_log] = ram_addr;
                n_log++;
            end
            @(posedge clk); #1;
            lat++;
        end
        last_lat = lat;
        check({tag, "_lat"}, lat, e_lat);
        check({tag, "_found"}, found, e_found);
        check({tag, "_maddr"}, match_addr, e_addr);
        @(posedge clk); #1;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_wr_ready"}, wr_ready, 1);
    endtask

    initial begin
        int good;
        int pulses;
        rst_n   = 1'b0;
        start   = 1'b0;
        key     = '0;
        wr_en   = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_found", found, 0);
        check("rst_maddr", match_addr, 0);
        check("rst_ram_rw", ram_rw, 0);
`ifdef SEARCH_COUNT_EN
        check("rst_match_cnt", match_cnt, 0);
`endif
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_wr_ready", wr_ready, 1);

        clear_mem();

        // Write path drives the RAM directly in IDLE.
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 3'b101;
        #1;
        check("wr_ram_rw", ram_rw, 1);
        check("wr_ram_addr", ram_addr, 7);
        check("wr_ram_wdata", ram_wdata, 5);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("wr_mem7", mem[7], 5);

        run_search(3'b101, exp_lat(7), 1, 7, "hit7");

        // No match anywhere: full sweep, addresses 0..31 in order.
        host_write(7, 0);
        run_search(3'b111, 33, 0, 0, "nomatch");
        good = 0;
        for (int i = 0; i < 32; i++) if (addr_log[i] == i) good++;
        check("nomatch_addr_seq", good, 32);
        check("nomatch_addr_cnt", (n_log >= 32) ? 1 : 0, 1);

        // Boundaries.
        host_write(0, 4);
        run_search(3'b100, exp_lat(0), 1, 0, "hit0");
        host_write(0, 0);
        host_write(31, 4);
        run_search(3'b100, 33, 1, 31, "hit31");
        host_write(31, 0);

        // Write and start together: write wins, start stays pending.
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 3'd3;
        start = 1'b1; key = 3'd3;
        #1;
        check("arb_ram_rw", ram_rw, 1);
        check("arb_ram_addr", ram_addr, 5);
        @(posedge clk); #1;
        wr_en = 1'b0;
        check("arb_not_busy", busy, 0);
        check("arb_mem5", mem[5], 3);
        @(posedge clk); #1;
        check("arb_busy", busy, 1);
        start = 1'b0;
        key   = 3'd0;
        @(posedge clk); #1;
        // Host write attempt while scanning must be refused.
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 3'd6;
        #1;
        check("busy_wr_ready", wr_ready, 0);
        check("busy_ram_rw", ram_rw, 0);
        @(posedge clk); #1;
        wr_en = 1'b0;
        begin
            int lat;
            lat = 2;
            while (!done && lat < 200) begin
                @(posedge clk); #1;
                lat++;
            end
            check("arb_lat", lat, exp_lat(5));
        end
        check("arb_found", found, 1);
        check("arb_maddr", match_addr, 5);
        check("busy_mem20", mem[20], 0);
        @(posedge clk); #1;

        // Reset in the middle of a scan aborts it without a done pulse.
        start = 1'b1; key = 3'b111;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("mid_busy", busy, 1);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_found", found, 0);
        check("mid_rst_maddr", match_addr, 0);
        check("mid_rst_ram_rw", ram_rw, 0);
        rst_n = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (done || busy) pulses++;
        end
        check("post_rst_quiet", pulses, 0);
        check("post_rst_wr_ready", wr_ready, 1);

        // Several matches: first address reported; counting mode sees all three.
        host_write(5, 0);
        host_write(2, 6);
        host_write(9, 6);
        host_write(30, 6);
        run_search(3'b110, exp_lat(2), 1, 2, "multi");
`ifdef SEARCH_COUNT_EN
        check("multi_match_cnt", match_cnt, 3);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
